// File: rtl/mem_resp.sv
// Bus-side memory responder: accepts active-low read/write requests for its segment,
// performs the access in internal RAM after a fixed wait and holds ok_ until the request drops.
module mem_resp #(
   parameter int AW      = 10,
   parameter int SEG     = 0,
   parameter int LATENCY = 2
) (
   input  logic        clk_sys,
   input  logic        clr_,
   input  logic        r_,
   input  logic        w_,
   input  logic [0:3]  nb_,
   input  logic [0:15] dad_,
   input  logic [0:15] ddt_,
   output logic [0:15] rdt_,
   output logic        ok_,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, WAIT, ACK, IGNORE} state_t;

   state_t          state_reg;
   state_t          state_next;
   logic [3:0]      cnt_reg;
   logic            write_reg;
   logic [AW-1:0]   addr_reg;
   logic [15:0]     wdata_reg;
   logic [15:0]     rdt_reg;
   logic [15:0]     mem [0:(2**AW)-1];

   logic [0:15]     addr_full;
   logic            req_idle;
   logic            req_one;
   logic            seg_hit;
   logic            in_range;
   logic            accept;
   logic            do_access;

   // Request decode; bus lines are active-low, so everything is inverted once here.
   assign addr_full = ~dad_;
   assign req_idle  = r_ & w_;
   assign req_one   = r_ ^ w_;
   assign seg_hit   = (~nb_) == 4'(SEG);
   assign in_range  = addr_full[0:15-AW] == '0;
   assign accept    = (state_reg == IDLE) && req_one && seg_hit && in_range;
   assign do_access = (state_reg == WAIT) && !req_idle && (cnt_reg == 4'd0);

   always_ff @(posedge clk_sys or negedge clr_) begin
      if (!clr_) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (!req_idle) state_next = accept ? WAIT : IGNORE;
         WAIT:    if (req_idle) state_next = IDLE;
                  else if (cnt_reg == 4'd0) state_next = ACK;
         ACK:     if (req_idle) state_next = IDLE;
         IGNORE:  if (req_idle) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Transaction latches: only values captured at the accept edge drive the access.
   always_ff @(posedge clk_sys or negedge clr_) begin
      if (!clr_) begin
         cnt_reg   <= 4'd0;
         write_reg <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= 16'h0000;
         rdt_reg   <= 16'hFFFF;
      end else begin
         if (accept) begin
            write_reg <= !w_;
            addr_reg  <= addr_full[16-AW:15];
            wdata_reg <= ~ddt_;
            cnt_reg   <= 4'(LATENCY);
         end else if ((state_reg == WAIT) && !req_idle && (cnt_reg != 4'd0)) begin
            cnt_reg <= cnt_reg - 4'd1;
         end

         if (do_access && !write_reg) begin
            rdt_reg <= ~mem[addr_reg];
         end else if ((state_reg == ACK) && req_idle) begin
            rdt_reg <= 16'hFFFF;
         end
      end
   end

   // RAM has no reset; state is forced to IDLE under clr_, so no write can slip through.
   always_ff @(posedge clk_sys) begin
      if (do_access && write_reg) begin
         mem[addr_reg] <= wdata_reg;
      end
   end

   always_comb begin
      ok_  = (state_reg != ACK);
      busy = (state_reg != IDLE);
      rdt_ = rdt_reg;
   end

endmodule

// File: doc/mem_resp.md
Name: mem_resp

Overview:
- Memory module that sits on the far end of the system bus from the P-A unit.
- Accepts active-low address (dad_), write data (ddt_) and segment (nb_), performs a word read or write into internal RAM, and answers with ok_ and active-low read data (rdt_).
- Uses a four-phase request/acknowledge handshake.
- Unmapped or malformed requests get no answer; the CPU's bus-timeout path handles them.

Parameters:
- AW, 10, RAM address width; the module holds 2^AW 16-bit words.
- SEG, 0, 4-bit segment number this module answers to.
- LATENCY, 2, extra wait cycles before acknowledge (0..15).

Ports:
- clk_sys  input  1  system clock; all state changes on its rising edge.
- clr_  input  1  reset, asynchronous, active-low.
- r_  input  1  read request, active-low.
- w_  input  1  write request, active-low.
- nb_  input  [0:3]  segment number, active-low.
- dad_  input  [0:15]  word address, active-low; the effective address is ~dad_.
- ddt_  input  [0:15]  write data, active-low; the stored value is ~ddt_.
- rdt_  output  [0:15]  read data, active-low; all ones when not driving.
- ok_  output  1  acknowledge, active-low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (clr_ low, asynchronous):
  - State goes to IDLE.
  - ok_=1, rdt_=16'hFFFF, busy=0, wait counter cleared.
  - RAM contents are not cleared.
  - Reset in the middle of an operation aborts it; a pending write is not performed.
- States: IDLE, WAIT, ACK, IGNORE.
- IDLE, sampled at each edge:
  - r_=1 and w_=1: stay in IDLE.
  - Exactly one of r_/w_ low, ~nb_==SEG, and ~dad_[0:15-AW]==0: this is the accept edge. Latch the operation, address ~dad_[16-AW:15] and data ~ddt_. Load counter=LATENCY. Go to WAIT.
  - Both r_ and w_ low, segment mismatch, or address out of range: go to IGNORE.
- WAIT:
  - If r_=1 and w_=1 are sampled (request withdrawn): go to IDLE, with no RAM write and no ok_.
  - Else if counter!=0: decrement.
  - Else (counter==0): perform the access and go to ACK.
    - Write: RAM[addr] <= latched data.
    - Read: rdt_ <= ~RAM[addr].
  - Only the values latched at the accept edge are used; bus changes during WAIT are ignored.
- ACK:
  - ok_=0, and rdt_ holds data for reads (stays FFFF for writes).
  - Sampling r_=1 and w_=1 moves to IDLE; ok_=1 and rdt_=FFFF take effect from that same edge.
  - Otherwise stay in ACK indefinitely. There is no timeout.
- IGNORE:
  - ok_ and rdt_ stay inactive.
  - Return to IDLE once r_=1 and w_=1 are sampled. This prevents a held request from retriggering.
- Latency: if the accept edge is edge k, ok_ goes low after edge k+1+LATENCY. With LATENCY=0 that is after edge k+1.
- Back-to-back requests: the earliest next accept is the edge after the return to IDLE. A request that is still low on the edge that leaves ACK does not cause that exit. Each transaction therefore needs at least one sampled idle cycle.
- The RAM is read and written synchronously inside the block.
- Outputs are registered; there are no combinational paths from inputs to ok_ or rdt_.

Test Plan:
1. Write, then read back (SEG=0, LATENCY=2):
   - Write: w_=0, dad_=~16'h0005, ddt_=~16'h1234, nb_=4'hF → ok_ goes low 3 cycles after the accept edge. Release w_ → ok_=1 on the next edge.
   - Read: r_=0, same address → ok_ low after 3 cycles with rdt_=~16'h1234. Release → rdt_=FFFF.
2. Segment mismatch: nb_=~4'h3 with SEG=0, read held for 40 cycles → ok_ stays 1, busy=1 in IGNORE. Release → IDLE. The next valid request is acknowledged normally.
3. Address out of range: AW=10, dad_=~16'h0400, write of ~16'hBEEF → no ok_. A later read of address 0 returns its earlier value, not BEEF.
4. Abort: write of 16'h5555 to address 7 (previously 16'h0000), w_ released while in WAIT → no ok_, IDLE on the next edge. A later read of address 7 returns 16'h0000.
5. Reset in ACK: assert clr_ while ok_=0 during a read → ok_=1 and rdt_=FFFF immediately, without waiting for a clock. RAM keeps earlier data.
6. Both r_=0 and w_=0 → IGNORE, no access. With LATENCY=0, a normal read is acknowledged after edge k+1. Back-to-back requests with a single idle cycle between them → both acknowledged.
